// File: rtl/mc_cu.sv
// Multicycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencing with a
// memory-wait timeout and illegal-instruction trap.
module mc_cu #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pcsource,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       aluimm,
  output logic       sext,
  output logic       jal,
  output logic [3:0] aluc,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam state_t      ERR_NEXT = HALT_ON_ERR ? S_HALT : S_IF;
  // Timeout fires on the wait cycle whose inclusive count equals MEM_TIMEOUT.
  localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t      cur, nxt;
  logic [15:0] cnt;
  logic        timeout;

  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic legal, imm_op;

  assign r_type = (op == 6'h00);
  assign i_add  = r_type & (func == 6'h20);
  assign i_sub  = r_type & (func == 6'h22);
  assign i_and  = r_type & (func == 6'h24);
  assign i_or   = r_type & (func == 6'h25);
  assign i_xor  = r_type & (func == 6'h26);
  assign i_sll  = r_type & (func == 6'h00);
  assign i_srl  = r_type & (func == 6'h02);
  assign i_sra  = r_type & (func == 6'h03);
  assign i_jr   = r_type & (func == 6'h08);
  assign i_addi = (op == 6'h08);
  assign i_andi = (op == 6'h0C);
  assign i_ori  = (op == 6'h0D);
  assign i_xori = (op == 6'h0E);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2B);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_lui  = (op == 6'h0F);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);

  assign imm_op = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign legal  = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                  imm_op | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (cnt == TO_LAST);
  assign state   = cur;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= S_IF;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (timeout || ((nxt != cur) && (nxt == S_IF || nxt == S_MEM)))
        cnt <= '0;
      else if (mem_req && !mem_ready)
        cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    nxt      = cur;
    mem_req  = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pcsource = 2'b00;
    wmem     = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    shift    = 1'b0;
    aluimm   = 1'b0;
    sext     = 1'b0;
    jal      = 1'b0;
    aluc     = 4'b0000;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    halted   = 1'b0;
    case (cur)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_ID;
        end else if (timeout) begin
          bus_err = 1'b1;
          nxt     = ERR_NEXT;
        end
      end
      S_ID: begin
        if (i_j || i_jal) begin
          pc_we    = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;
          jal      = i_jal;
          nxt      = S_IF;
        end else if (i_jr) begin
          pc_we    = 1'b1;
          pcsource = 2'b10;
          nxt      = S_IF;
        end else if (!legal) begin
          illegal = 1'b1;
          nxt     = ERR_NEXT;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        aluc[3] = i_sra;
        aluc[2] = i_sub | i_beq | i_bne | i_or | i_ori | i_lui | i_srl | i_sra;
        aluc[1] = i_xor | i_xori | i_lui | i_sll | i_srl | i_sra;
        aluc[0] = i_and | i_andi | i_or | i_ori | i_sll | i_srl | i_sra;
        shift   = i_sll | i_srl | i_sra;
        aluimm  = imm_op | i_lw | i_sw;
        sext    = i_addi | i_lw | i_sw | i_beq | i_bne | i_lui;
        if (i_beq || i_bne) begin
          pc_we    = (i_beq & z) | (i_bne & ~z);
          pcsource = 2'b01;
          nxt      = S_IF;
        end else if (i_lw || i_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          wmem = i_sw;
          nxt  = i_sw ? S_IF : S_WB;
        end else if (timeout) begin
          bus_err = 1'b1;
          nxt     = ERR_NEXT;
        end
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = imm_op | i_lw;
        m2reg = i_lw;
        nxt   = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_IF;
    endcase
    // Reset wins over any state: no request, write or error pulse escapes.
    if (reset) begin
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      wreg    = 1'b0;
      wmem    = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
      halted  = 1'b0;
    end
  end

endmodule
